fifo_uart_tx: RTL and testbench

- Drains the 8-bit sample FIFO filled by the polling controller (AD bytes followed by 0x0D 0x0A per sweep).
- Serialises each byte onto an 8N1 UART line to the host PC.
- Acts as the FIFO reader: it drives rdreq and consumes empty and q. It owns no storage beyond a one-byte shift register.
- Sits between the AD FIFO read port and the board UART TX pin, clocked from the same 100 MHz domain.

---
 rtl/fifo_uart_tx.sv | 154 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: reads bytes from a normal-mode FIFO and sends each one on an
// 8N1 UART line, LSB first. The only data storage is a one-byte shift register.
module fifo_uart_tx #(
    parameter int unsigned BAUD_DIV  = 868,  // clk cycles per UART bit, 4..65535
    parameter int unsigned STOP_BITS = 1     // 1 or 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       empty,
    input  logic [7:0] q,
    output logic       rdreq,
    output logic       tx,
    output logic       busy,
    output logic       byte_done,
    output logic       line_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    logic [2:0]  state_q,     state_d;
    logic        tx_q,        tx_d;
    logic        rdreq_q,     rdreq_d;
    logic        byte_done_q, byte_done_d;
    logic        line_done_q, line_done_d;
    logic [7:0]  shreg_q,     shreg_d;
    logic [2:0]  bit_cnt_q,   bit_cnt_d;
    logic [15:0] baud_cnt_q,  baud_cnt_d;
    logic        baud_end;

    assign baud_end = (baud_cnt_q == BAUD_LAST);

    // Next-state and next-output logic for the read/serialise sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would infer a latch.
        state_d     = state_q;
        tx_d        = tx_q;
        rdreq_d     = 1'b0;
        byte_done_d = 1'b0;
        line_done_d = 1'b0;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        baud_cnt_d  = baud_cnt_q;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (en && !empty) begin
                    rdreq_d = 1'b1;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                // rdreq drops back to 0 by default: exactly one read per byte.
                state_d = S_LATCH;
            end
            S_LATCH: begin
                shreg_d    = q;
                tx_d       = 1'b0;
                baud_cnt_d = 16'd0;
                state_d    = S_START;
            end
            S_START: begin
                if (baud_end) begin
                    baud_cnt_d = 16'd0;
                    tx_d       = shreg_q[0];
                    bit_cnt_d  = 3'd0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_cnt_d = 16'd0;
                    // Rotate rather than shift in zeros: after eight bit periods
                    // the register holds the original byte again, which the stop
                    // state uses to recognise a line feed.
                    shreg_d    = {shreg_q[0], shreg_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tx_d = shreg_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                // bit_cnt counts stop bits here (it wrapped to 0 leaving DATA).
                if (baud_end) begin
                    baud_cnt_d = 16'd0;
                    if (bit_cnt_q == STOP_LAST) begin
                        byte_done_d = 1'b1;
                        line_done_d = (shreg_q == 8'h0A);
                        bit_cnt_d   = 3'd0;
                        state_d     = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drives the line idle-high immediately.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples the values from
        // before this edge, independent of statement order.
        if (reset) begin
            state_q     <= S_IDLE;
            tx_q        <= 1'b1;
            rdreq_q     <= 1'b0;
            byte_done_q <= 1'b0;
            line_done_q <= 1'b0;
            shreg_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            baud_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rdreq_q     <= rdreq_d;
            byte_done_q <= byte_done_d;
            line_done_q <= line_done_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            baud_cnt_q  <= baud_cnt_d;
        end
    end

    assign rdreq     = rdreq_q;
    assign tx        = tx_q;
    assign busy      = (state_q != S_IDLE);
    assign byte_done = byte_done_q;
    assign line_done = line_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: instance A (BAUD_DIV=16, 1 stop bit) is fed
// by a queue-based FIFO model and watched by a UART receiver; instance B
// (BAUD_DIV=8, 2 stop bits) covers the two-stop-bit frame.
module tb_fifo_uart_tx;

    localparam int BD_A = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // Instance A signals and FIFO model
    logic       en_a = 1'b0;
    logic       empty_a = 1'b1;
    logic [7:0] q_a = 8'h00;
    logic       rdreq_a, tx_a, busy_a, byte_done_a, line_done_a;
    logic       wr_a = 1'b0;
    logic [7:0] wr_data_a = 8'h00;
    logic [7:0] fifo_a[$];

    // Instance B signals and one-entry source
    logic       en_b = 1'b0;
    logic       full_b = 1'b0;
    logic       empty_b;
    logic [7:0] q_b = 8'h00;
    logic [7:0] data_b = 8'h00;
    logic       rdreq_b, tx_b, busy_b, byte_done_b, line_done_b;
    logic       wr_b = 1'b0;
    logic [7:0] wr_data_b = 8'h00;

    int checks = 0;
    int errors = 0;

    // Monitor state (written only by the monitor process)
    int cyc = 0;
    int rd_cnt = 0, bd_cnt = 0, ld_cnt = 0, fall_cnt = 0, rx_err = 0;
    int last_rd_cyc = 0, last_bd_cyc = 0, last_ld_cyc = 0, last_fall_cyc = 0, last_ef_cyc = 0;
    int rd_b_cnt = 0, bd_b_cnt = 0, ld_b_cnt = 0, low_b_cnt = 0;
    int fall_b_cyc = 0, rise_b_cyc = 0, bd_b_cyc = 0;
    logic tx_prev = 1'b1, tx_b_prev = 1'b1, empty_prev = 1'b1;
    logic rx_active = 1'b0;
    int rx_t = 0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_q[$];
    int gap_q[$];

    always #5 clk = ~clk;

    fifo_uart_tx #(.BAUD_DIV(16), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .en(en_a), .empty(empty_a), .q(q_a),
        .rdreq(rdreq_a), .tx(tx_a), .busy(busy_a),
        .byte_done(byte_done_a), .line_done(line_done_a)
    );

    fifo_uart_tx #(.BAUD_DIV(8), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .empty(empty_b), .q(q_b),
        .rdreq(rdreq_b), .tx(tx_b), .busy(busy_b),
        .byte_done(byte_done_b), .line_done(line_done_b)
    );

    // Normal-mode FIFO model: q updates on the edge that samples rdreq high.
    always @(posedge clk) begin
        if (rdreq_a && fifo_a.size() > 0) q_a <= fifo_a.pop_front();
        if (wr_a) fifo_a.push_back(wr_data_a);
        empty_a <= (fifo_a.size() == 0);
    end

    // One-entry source for instance B.
    always @(posedge clk) begin
        if (rdreq_b && full_b) begin
            q_b    <= data_b;
            full_b <= 1'b0;
        end
        if (wr_b) begin
            data_b <= wr_data_b;
            full_b <= 1'b1;
        end
    end
    assign empty_b = !full_b;

    // Event counters and UART receiver, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rdreq_a)     begin rd_cnt++; last_rd_cyc = cyc; end
        if (byte_done_a) begin bd_cnt++; last_bd_cyc = cyc; end
        if (line_done_a) begin ld_cnt++; last_ld_cyc = cyc; end
        if (empty_prev && !empty_a) last_ef_cyc = cyc;
        empty_prev = empty_a;
        if (reset) begin
            rx_active = 1'b0;
        end else if (rx_active) begin
            rx_t++;
            if (rx_t % BD_A == BD_A / 2) begin
                if (rx_t / BD_A == 0) begin
                    if (tx_a !== 1'b0) rx_err++;
                end else if (rx_t / BD_A <= 8) begin
                    rx_byte[rx_t / BD_A - 1] = tx_a;
                end else begin
                    if (tx_a !== 1'b1) rx_err++;
                    rx_q.push_back(rx_byte);
                    rx_active = 1'b0;
                end
            end
        end else if (tx_prev && !tx_a) begin
            rx_active = 1'b1;
            rx_t = 0;
            fall_cnt++;
            last_fall_cyc = cyc;
            gap_q.push_back(cyc - last_bd_cyc);
        end
        tx_prev = tx_a;

        if (rdreq_b) rd_b_cnt++;
        if (byte_done_b) begin bd_b_cnt++; bd_b_cyc = cyc; end
        if (line_done_b) ld_b_cnt++;
        if (tx_b === 1'b0) low_b_cnt++;
        if (tx_b_prev === 1'b1 && tx_b === 1'b0) fall_b_cyc = cyc;
        if (tx_b_prev === 1'b0 && tx_b === 1'b1) rise_b_cyc = cyc;
        tx_b_prev = tx_b;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_a(input logic [7:0] b);
        wr_a = 1'b1;
        wr_data_a = b;
        step(1);
        wr_a = 1'b0;
    endtask

    task automatic wait_bd(input int target, input int budget, input string tag);
        int n = 0;
        while (bd_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        check(tag, int'(bd_cnt >= target), 1);
    endtask

    task automatic wait_fall(input int target, input int budget, input string tag);
        int n = 0;
        while (fall_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        check(tag, int'(fall_cnt >= target), 1);
    endtask

    initial begin
        int rd0, bd0, ld0, f0, r0, n;

        // Reset state
        step(3);
        check("rst_tx", int'(tx_a), 1);
        check("rst_rdreq", int'(rdreq_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_byte_done", int'(byte_done_a), 0);
        check("rst_line_done", int'(line_done_a), 0);
        reset = 1'b0;
        step(2);

        // T2: single byte 0x55
        rd0 = rd_cnt; bd0 = bd_cnt; ld0 = ld_cnt; r0 = rx_q.size();
        push_a(8'h55);
        en_a = 1'b1;
        wait_bd(bd0 + 1, 300, "t2_timeout");
        check("t2_rdreq_pulses", rd_cnt - rd0, 1);
        check("t2_start_latency", last_fall_cyc - last_rd_cyc, 2);
        check("t2_byte_done_at", last_bd_cyc - last_fall_cyc, 160);
        check("t2_line_done", ld_cnt - ld0, 0);
        step(2);
        check("t2_rx_byte", int'(rx_q[r0]), 8'h55);

        // T3: line burst 12 34 0D 0A
        en_a = 1'b0;
        rd0 = rd_cnt; bd0 = bd_cnt; ld0 = ld_cnt; r0 = rx_q.size(); f0 = gap_q.size();
        push_a(8'h12); push_a(8'h34); push_a(8'h0D); push_a(8'h0A);
        en_a = 1'b1;
        wait_bd(bd0 + 4, 1000, "t3_timeout");
        step(2);
        check("t3_rdreq_pulses", rd_cnt - rd0, 4);
        check("t3_rx0", int'(rx_q[r0]), 8'h12);
        check("t3_rx1", int'(rx_q[r0 + 1]), 8'h34);
        check("t3_rx2", int'(rx_q[r0 + 2]), 8'h0D);
        check("t3_rx3", int'(rx_q[r0 + 3]), 8'h0A);
        // byte_done lands in the IDLE cycle; RD and LATCH follow at idle-high,
        // so the next start bit appears 3 cycles after byte_done.
        check("t3_gap1", gap_q[f0 + 1], 3);
        check("t3_gap2", gap_q[f0 + 2], 3);
        check("t3_gap3", gap_q[f0 + 3], 3);
        check("t3_line_done_cnt", ld_cnt - ld0, 1);
        check("t3_line_done_on_4th", last_ld_cyc, last_bd_cyc);

        // T4: en gating mid-frame with three bytes queued
        en_a = 1'b0;
        rd0 = rd_cnt; bd0 = bd_cnt; r0 = rx_q.size(); f0 = fall_cnt;
        push_a(8'hA1); push_a(8'hB2); push_a(8'hC3);
        en_a = 1'b1;
        wait_fall(f0 + 1, 20, "t4_start_timeout");
        step(72);
        en_a = 1'b0;
        wait_bd(bd0 + 1, 200, "t4_byte1_timeout");
        step(5);
        check("t4_busy_low", int'(busy_a), 0);
        check("t4_one_read", rd_cnt - rd0, 1);
        check("t4_fifo_left", fifo_a.size(), 2);
        check("t4_rx_a1", int'(rx_q[r0]), 8'hA1);
        step(40);
        check("t4_no_new_read", rd_cnt - rd0, 1);
        check("t4_tx_idle", int'(tx_a), 1);
        en_a = 1'b1;
        wait_bd(bd0 + 3, 500, "t4_rest_timeout");
        step(2);
        check("t4_rx_b2", int'(rx_q[r0 + 1]), 8'hB2);
        check("t4_rx_c3", int'(rx_q[r0 + 2]), 8'hC3);
        check("t4_reads", rd_cnt - rd0, 3);

        // T5: FIFO runs empty, then a new write resumes
        en_a = 1'b0;
        rd0 = rd_cnt; bd0 = bd_cnt; r0 = rx_q.size();
        push_a(8'h5A); push_a(8'h3C);
        en_a = 1'b1;
        wait_bd(bd0 + 2, 500, "t5_timeout");
        step(40);
        check("t5_two_reads", rd_cnt - rd0, 2);
        check("t5_tx_idle", int'(tx_a), 1);
        check("t5_busy_low", int'(busy_a), 0);
        push_a(8'h77);
        wait_bd(bd0 + 3, 300, "t5_resume_timeout");
        step(2);
        check("t5_resume_latency", last_fall_cyc - last_ef_cyc, 3);
        check("t5_rx_77", int'(rx_q[r0 + 2]), 8'h77);
        check("t5_reads", rd_cnt - rd0, 3);

        // T1: reset mid-DATA
        f0 = fall_cnt;
        push_a(8'h96);
        wait_fall(f0 + 1, 20, "t1_start_timeout");
        step(48);
        check("t1_in_data_tx", int'(busy_a), 1);
        reset = 1'b1;
        #1;
        check("t1_async_tx", int'(tx_a), 1);
        check("t1_async_rdreq", int'(rdreq_a), 0);
        check("t1_async_busy", int'(busy_a), 0);
        check("t1_async_byte_done", int'(byte_done_a), 0);
        step(2);
        reset = 1'b0;
        rd0 = rd_cnt;
        step(50);
        check("t1_no_read_empty", rd_cnt - rd0, 0);
        check("t1_tx_idle", int'(tx_a), 1);
        check("t1_rx_errors", rx_err, 0);

        // T6: instance B, 0xFF with two stop bits
        wr_b = 1'b1;
        wr_data_b = 8'hFF;
        step(1);
        wr_b = 1'b0;
        en_b = 1'b1;
        n = 0;
        while (bd_b_cnt < 1 && n < 200) begin
            step(1);
            n++;
        end
        check("t6_timeout", int'(bd_b_cnt >= 1), 1);
        check("t6_reads", rd_b_cnt, 1);
        check("t6_start_len", rise_b_cyc - fall_b_cyc, 8);
        check("t6_low_total", low_b_cnt, 8);
        check("t6_byte_done_at", bd_b_cyc - fall_b_cyc, 88);
        check("t6_line_done", ld_b_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
